// File: rtl/quad_gen.sv
// Quadrature encoder emulator: walks quadA/quadB toward a commanded 32-bit target, one edge per
// period_r clocks. Define QUAD_GEN_INDEX_EN to generate an index pulse every CPR counts.
module quad_gen #(
   parameter int unsigned PERIOD_W = 16,
   parameter int unsigned CPR      = 2048
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [31:0]         target,
   input  logic [PERIOD_W-1:0] period,
   input  logic                pos_load,
   input  logic [31:0]         pos_value,
   output logic                quadA,
   output logic                quadB,
   output logic [31:0]         position,
   output logic                busy,
   output logic                done,
   output logic                index
);

   localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);

   typedef enum logic {StIdle, StMove} state_e;

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [31:0]         target_q, target_d;
   logic [31:0]         pos_q, pos_d;
   logic                a_q, a_d, b_q, b_d;
   logic                done_q, done_d;

   logic [31:0] diff;
   logic [31:0] pos_step;
   logic        step_up;
   logic        edge_en;

   assign diff     = target_q - pos_q;
   assign step_up  = ~diff[31];
   assign pos_step = step_up ? pos_q + 32'd1 : pos_q - 32'd1;

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      period_d = period_q;
      target_d = target_q;
      pos_d    = pos_q;
      a_d      = a_q;
      b_d      = b_q;
      done_d   = 1'b0;
      edge_en  = 1'b0;
      if (pos_load) begin
         pos_d    = pos_value;
         target_d = pos_value;
         tick_d   = '0;
         state_d  = StIdle;
      end else if (cmd_valid) begin
         // Accepting a command restarts the edge timer, so no edge can fire on this clock.
         target_d = target;
         period_d = (period == '0) ? PeriodOne : period;
         tick_d   = '0;
         state_d  = (target == pos_q) ? StIdle : StMove;
      end else begin
         unique case (state_q)
            StIdle: begin
               tick_d = '0;
               if (diff != 32'd0) state_d = StMove;
            end
            StMove: begin
               if (tick_q == period_q - PeriodOne) begin
                  edge_en = 1'b1;
                  tick_d  = '0;
                  pos_d   = pos_step;
                  // Forward AB walk 00->10->11->01; reverse walks it backwards.
                  a_d     = step_up ? ~b_q : b_q;
                  b_d     = step_up ? a_q : ~a_q;
                  if (pos_step == target_q) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + PeriodOne;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         tick_q   <= '0;
         period_q <= PeriodOne;
         target_q <= '0;
         pos_q    <= '0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         target_q <= target_d;
         pos_q    <= pos_d;
         a_q      <= a_d;
         b_q      <= b_d;
         done_q   <= done_d;
      end
   end

   assign cmd_ready = reset_n;
   assign quadA     = a_q;
   assign quadB     = b_q;
   assign position  = pos_q;
   assign busy      = (target_q != pos_q);
   assign done      = done_q;

`ifdef QUAD_GEN_INDEX_EN
   localparam int unsigned IdxW = (CPR > 1) ? $clog2(CPR) : 1;
   localparam logic [IdxW-1:0] IdxMax = IdxW'(CPR - 1);

   logic [IdxW-1:0] idx_cnt_q, idx_cnt_d;
   logic            index_q, index_d;

   always_comb begin
      idx_cnt_d = idx_cnt_q;
      if (pos_load) begin
         idx_cnt_d = '0;
      end else if (edge_en) begin
         if (step_up) idx_cnt_d = (idx_cnt_q == IdxMax) ? '0 : idx_cnt_q + IdxW'(1);
         else         idx_cnt_d = (idx_cnt_q == '0) ? IdxMax : idx_cnt_q - IdxW'(1);
      end
      index_d = (idx_cnt_d == '0) && !a_d && !b_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx_cnt_q <= '0;
         index_q   <= 1'b1;
      end else begin
         idx_cnt_q <= idx_cnt_d;
         index_q   <= index_d;
      end
   end

   assign index = index_q;
`else
   assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: time-based reference model of edge scheduling plus a
// behavioural quadrature decoder fed from the DUT outputs.
module tb_quad_gen;

   localparam int unsigned PW  = 16;
   localparam int unsigned CPR = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [31:0]   target = '0;
   logic [PW-1:0] period = '0;
   logic          pos_load = 1'b0;
   logic [31:0]   pos_value = '0;
   logic          quadA, quadB, busy, done, index;
   logic [31:0]   position;

   quad_gen #(.PERIOD_W(PW), .CPR(CPR)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .target(target), .period(period), .pos_load(pos_load), .pos_value(pos_value),
      .quadA(quadA), .quadB(quadB), .position(position), .busy(busy), .done(done),
      .index(index)
   );

   always #5 clk = ~clk;

   logic [36:0] obs;
   assign obs = {quadA, quadB, position, busy, done, index};

   // Reference model state
   logic [31:0] m_pos, m_tgt, m_base;
   int unsigned m_per;
   int          m_phase;
   logic        m_done;
   longint      cyc, m_next;
   // Behavioural decoder driven by DUT outputs
   logic [31:0] dec_cnt;
   logic [1:0]  ab_prev;
   int          done_cnt;
   int          passed = 0, total = 0;

   function automatic logic [1:0] ab_of(input int ph);
      case (ph)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic logic [36:0] model_vec();
      logic ix;
`ifdef QUAD_GEN_INDEX_EN
      ix = (((m_pos - m_base) % CPR) == 0) && (m_phase == 0);
`else
      ix = 1'b0;
`endif
      return {ab_of(m_phase), m_pos, m_pos != m_tgt, m_done, ix};
   endfunction

   task automatic model_reset();
      m_pos = '0; m_tgt = '0; m_base = '0; m_per = 1; m_phase = 0; m_done = 1'b0;
      m_next = 0; ab_prev = 2'b00; dec_cnt = '0;
   endtask

   // One clock: drive inputs, advance the model for this edge, sample #1 later.
   task automatic tick(input logic cv, input logic [31:0] tg, input logic [PW-1:0] per,
                       input logic ld, input logic [31:0] lv);
      logic signed [31:0] d;
      cmd_valid = cv; target = tg; period = per; pos_load = ld; pos_value = lv;
      @(posedge clk);
      cyc++;
      m_done = 1'b0;
      if (ld) begin
         m_pos = lv; m_tgt = lv; m_base = lv;
      end else if (cv) begin
         m_tgt  = tg;
         m_per  = (per == 0) ? 1 : per;
         m_next = cyc + m_per;
      end else if (m_pos != m_tgt && cyc == m_next) begin
         d = m_tgt - m_pos;
         if (d > 0) begin m_pos = m_pos + 1; m_phase = (m_phase + 1) % 4; end
         else       begin m_pos = m_pos - 1; m_phase = (m_phase + 3) % 4; end
         m_next = cyc + m_per;
         m_done = (m_pos == m_tgt);
      end
      #1;
      cmd_valid = 1'b0; pos_load = 1'b0;
      if ({quadA, quadB} != ab_prev) begin
         if (quadA ^ ab_prev[0]) dec_cnt = dec_cnt + 1;
         else                    dec_cnt = dec_cnt - 1;
      end
      ab_prev = {quadA, quadB};
      if (done) done_cnt++;
   endtask

   task automatic idle();
      tick(1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      logic [36:0] want;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      cyc = 0;
`ifdef QUAD_GEN_INDEX_EN
      want = {2'b00, 32'd0, 1'b0, 1'b0, 1'b1};
`else
      want = {2'b00, 32'd0, 1'b0, 1'b0, 1'b0};
`endif
      total++;
      if (obs !== want) $display("FAIL reset_state got=%h want=%h", obs, want);
      else passed++;
      total++;
      if (cmd_ready !== 1'b1) $display("FAIL cmd_ready got=%b want=1", cmd_ready);
      else passed++;
   endtask

   task automatic test_basic();
      int d0;
      d0 = done_cnt;
      tick(1'b1, 32'd4, 16'd3, 1'b0, '0);
      for (int i = 0; i < 14; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL basic_cyc%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
         if (i == 2) begin
            total++;
            if ({quadA, quadB, position} !== {2'b10, 32'd1})
               $display("FAIL basic_first_edge got=%b%b/%0d want=10/1", quadA, quadB, position);
            else passed++;
         end
      end
      total++;
      if (position !== 32'd4 || done_cnt - d0 != 1 || busy !== 1'b0)
         $display("FAIL basic_end got=pos %0d dones %0d busy %b want=pos 4 dones 1 busy 0",
                  position, done_cnt - d0, busy);
      else passed++;
   endtask

   task automatic test_reverse();
      tick(1'b1, 32'd2, 16'd1, 1'b0, '0);
      idle();
      total++;
      if ({quadA, quadB, position, done} !== {2'b01, 32'd3, 1'b0})
         $display("FAIL reverse_1 got=%b%b/%0d/%b want=01/3/0", quadA, quadB, position, done);
      else passed++;
      idle();
      total++;
      if ({quadA, quadB, position, done, busy} !== {2'b11, 32'd2, 1'b1, 1'b0})
         $display("FAIL reverse_2 got=%b%b/%0d/%b/%b want=11/2/1/0", quadA, quadB, position,
                  done, busy);
      else passed++;
      idle();
      total++;
      if (obs !== model_vec()) $display("FAIL reverse_settle got=%h want=%h", obs, model_vec());
      else passed++;
   endtask

   task automatic test_period0();
      logic [31:0] p0;
      p0 = position;
      tick(1'b1, p0 + 32'd2, 16'd0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL period0_cyc%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
      end
      total++;
      if (position !== p0 + 32'd2) $display("FAIL period0_end got=%0d want=%0d", position, p0 + 2);
      else passed++;
   endtask

   task automatic test_retarget();
      int d0, guard;
      tick(1'b0, '0, '0, 1'b1, 32'd0);
      d0 = done_cnt;
      tick(1'b1, 32'd10, 16'd4, 1'b0, '0);
      guard = 0;
      while (position != 32'd3 && guard < 100) begin idle(); guard++; end
      total++;
      if (position !== 32'd3) $display("FAIL retarget_reach got=%0d want=3", position);
      else passed++;
      tick(1'b1, 32'd1, 16'd4, 1'b0, '0);
      for (int i = 0; i < 12; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL retarget_cyc%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
         if (i == 3) begin
            total++;
            if (position !== 32'd2) $display("FAIL retarget_first got=%0d want=2", position);
            else passed++;
         end
      end
      total++;
      if (position !== 32'd1 || done_cnt - d0 != 1)
         $display("FAIL retarget_end got=pos %0d dones %0d want=pos 1 dones 1", position,
                  done_cnt - d0);
      else passed++;
   endtask

   task automatic test_same_target();
      int d0;
      d0 = done_cnt;
      tick(1'b1, position + 32'd6, 16'd2, 1'b0, '0);
      repeat (5) idle();
      tick(1'b1, position, 16'd2, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL same_tgt_cyc%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
      end
      total++;
      if (done_cnt != d0) $display("FAIL same_tgt_done got=%0d want=0", done_cnt - d0);
      else passed++;
   endtask

   task automatic test_load_wrap();
      logic [1:0] ab0;
      ab0 = {quadA, quadB};
      // Load and command together: load wins, command is dropped.
      tick(1'b1, 32'd50, 16'd1, 1'b1, 32'h7FFF_FFFE);
      total++;
      if ({quadA, quadB, position, busy, done} !== {ab0, 32'h7FFF_FFFE, 1'b0, 1'b0})
         $display("FAIL load got=%h want=%h", {quadA, quadB, position, busy, done},
                  {ab0, 32'h7FFF_FFFE, 2'b00});
      else passed++;
      repeat (3) idle();
      total++;
      if (obs !== model_vec()) $display("FAIL load_hold got=%h want=%h", obs, model_vec());
      else passed++;
      tick(1'b1, 32'h8000_0001, 16'd1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         idle();
         total++;
         if (position !== 32'h7FFF_FFFF + i)
            $display("FAIL wrap_%0d got=%h want=%h", i, position, 32'h7FFF_FFFF + i);
         else passed++;
         total++;
         if (obs !== model_vec()) $display("FAIL wrap_vec%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
      end
   endtask

   task automatic test_index();
      tick(1'b0, '0, '0, 1'b1, 32'd0);
      tick(1'b1, 32'd8, 16'd1, 1'b0, '0);
      for (int i = 0; i < 9; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL index_up%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
      end
      tick(1'b1, 32'd0, 16'd1, 1'b0, '0);
      for (int i = 0; i < 9; i++) begin
         idle();
         total++;
         if (obs !== model_vec()) $display("FAIL index_dn%0d got=%h want=%h", i, obs, model_vec());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, position + 32'd20, 16'd1, 1'b0, '0);
      repeat (5) idle();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      total++;
      if (obs !== model_vec()) $display("FAIL reset_mid got=%h want=%h", obs, model_vec());
      else passed++;
   endtask

   task automatic test_random();
      logic [31:0] off, pos0;
      logic [1:0]  prev;
      int          n, guard;
      tick(1'b0, '0, '0, 1'b1, $urandom());
      dec_cnt = position;
      for (int k = 0; k < 25; k++) begin
         off = $urandom_range(0, 30);
         tick(1'b1, m_pos + off - 32'd15, PW'($urandom_range(0, 8)), 1'b0, '0);
         n = $urandom_range(1, 60);
         for (int i = 0; i < n; i++) begin
            prev = {quadA, quadB};
            idle();
            total++;
            if (obs !== model_vec()) $display("FAIL rand_k%0d_c%0d got=%h want=%h", k, i, obs,
                                              model_vec());
            else passed++;
            total++;
            if ((prev ^ {quadA, quadB}) == 2'b11)
               $display("FAIL rand_double got=%b->%b want=single-bit", prev, {quadA, quadB});
            else passed++;
         end
      end
      tick(1'b1, m_pos + 32'd37, 16'd8, 1'b0, '0);
      pos0  = position;
      guard = 0;
      while (busy && guard < 2000) begin idle(); guard++; end
      total++;
      if (busy !== 1'b0 || position !== pos0 + 32'd37)
         $display("FAIL rand_settle got=busy %b pos %h want=busy 0 pos %h", busy, position,
                  pos0 + 32'd37);
      else passed++;
      total++;
      if (dec_cnt !== position) $display("FAIL rand_decoder got=%h want=%h", dec_cnt, position);
      else passed++;
   endtask

   initial begin
      done_cnt = 0;
      cyc = 0;
      model_reset();
      test_reset();
      test_basic();
      test_reverse();
      test_period0();
      test_retarget();
      test_same_target();
      test_load_wrap();
      test_index();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
